// File: rtl/spdif_pkg.sv
// ----------------------------------------------------------------------------
// spdif_pkg
//   Shared types and helpers for the S/PDIF lock/rate controller.
//   - lock_state_t      : controller state encoding (also the lock_state output)
//   - CLS_*             : edge classification codes; 1..3 equal the UI count
//   - calc_thresholds() : decoder thresholds derived from the measured UI
//   - SUBFRAME_UI / PREAMBLE_GUARD : subframe spacing and preamble qualifier
// ----------------------------------------------------------------------------
package spdif_pkg;

    typedef enum logic [1:0] {
        LS_IDLE    = 2'd0,
        LS_MEASURE = 2'd1,
        LS_VERIFY  = 2'd2,
        LS_LOCKED  = 2'd3
    } lock_state_t;

    // Codes 1..3 are chosen so a legal class adds directly to the UI accumulator.
    localparam logic [2:0] CLS_RUNT = 3'd0;
    localparam logic [2:0] CLS_1    = 3'd1;
    localparam logic [2:0] CLS_2    = 3'd2;
    localparam logic [2:0] CLS_3    = 3'd3;
    localparam logic [2:0] CLS_LONG = 3'd4;

    localparam logic [6:0] SUBFRAME_UI    = 7'd64;
    localparam logic [6:0] PREAMBLE_GUARD = 7'd8;

    typedef struct packed {
        logic [7:0] t1;
        logic [7:0] t2;
        logic [7:0] t3;
    } thresh_t;

    // Boundaries sit half a UI above each nominal length. UI <= 63 keeps t3 <= 220.
    function automatic thresh_t calc_thresholds(input logic [7:0] ui);
        thresh_t    t;
        logic [7:0] half;
        half = ui >> 1;
        t.t1 = ui + half;
        t.t2 = (ui << 1) + half;
        t.t3 = (ui << 1) + ui + half;
        return t;
    endfunction

endpackage

// File: rtl/spdif_lock_ctrl_if.sv
// ----------------------------------------------------------------------------
// spdif_lock_ctrl_if
//   Bus between the edge correlator / preamble extractor and the lock controller.
//   master : drives ena, rx_edge, edge_len; observes configuration and status
//   slave  : the lock controller
//   Signals: ena, rx_edge, edge_len[7:0], cfg_ui/t1/t2/t3[7:0], cfg_valid,
//            audio_locked, lock_state[1:0], subframe_strobe, err_strobe
// ----------------------------------------------------------------------------
interface spdif_lock_ctrl_if;
    logic       ena;
    logic       rx_edge;
    logic [7:0] edge_len;
    logic [7:0] cfg_ui;
    logic [7:0] cfg_t1;
    logic [7:0] cfg_t2;
    logic [7:0] cfg_t3;
    logic       cfg_valid;
    logic       audio_locked;
    logic [1:0] lock_state;
    logic       subframe_strobe;
    logic       err_strobe;

    modport master (
        output ena, rx_edge, edge_len,
        input  cfg_ui, cfg_t1, cfg_t2, cfg_t3, cfg_valid,
               audio_locked, lock_state, subframe_strobe, err_strobe
    );

    modport slave (
        input  ena, rx_edge, edge_len,
        output cfg_ui, cfg_t1, cfg_t2, cfg_t3, cfg_valid,
               audio_locked, lock_state, subframe_strobe, err_strobe
    );
endinterface

// File: rtl/spdif_edge_classifier.sv
// ----------------------------------------------------------------------------
// spdif_edge_classifier
//   Combinational classification of one edge-to-edge length against the
//   current UI and thresholds.
//   i_len        : edge length in clk cycles (255 = saturated)
//   i_ui         : measured UI
//   i_t1..i_t3   : 1/2, 2/3 and 3/violation boundaries
//   o_cls        : CLS_RUNT, CLS_1, CLS_2, CLS_3 or CLS_LONG
// ----------------------------------------------------------------------------
module spdif_edge_classifier
    import spdif_pkg::*;
(
    input  logic [7:0] i_len,
    input  logic [7:0] i_ui,
    input  logic [7:0] i_t1,
    input  logic [7:0] i_t2,
    input  logic [7:0] i_t3,
    output logic [2:0] o_cls
);
    always_comb begin
        o_cls = CLS_LONG;
        if (i_len < (i_ui >> 1))
            o_cls = CLS_RUNT;
        else if (i_len <= i_t1)
            o_cls = CLS_1;
        else if (i_len <= i_t2)
            o_cls = CLS_2;
        else if (i_len <= i_t3)
            o_cls = CLS_3;
    end
endmodule

// File: rtl/spdif_lock_ctrl.sv
// ----------------------------------------------------------------------------
// spdif_lock_ctrl
//   Measures the S/PDIF unit interval, programs the decoder thresholds and
//   qualifies lock on 64-UI subframe spacing.
//   clk   : single clock
//   reset : synchronous, active-high
//   bus   : spdif_lock_ctrl_if.slave (ena, rx_edge, edge_len in; cfg_*, status out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no signal; first edge starts a measurement (its len dropped)
//   MEASURE | track minimum edge_len over WIN_EDGES edges
//   VERIFY  | cfg_* loaded; need LOCK_COUNT consecutive good subframes
//   LOCKED  | audio_locked; ERR_LIMIT consecutive bad events drop to MEASURE
// ----------------------------------------------------------------------------
module spdif_lock_ctrl
    import spdif_pkg::*;
#(
    parameter int WIN_EDGES  = 128,
    parameter int MIN_UI     = 4,
    parameter int MAX_UI     = 63,
    parameter int LOCK_COUNT = 8,
    parameter int ERR_LIMIT  = 4,
    parameter int TIMEOUT    = 1023
) (
    input logic             clk,
    input logic             reset,
    spdif_lock_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE    = LS_IDLE;
    localparam logic [1:0] S_MEASURE = LS_MEASURE;
    localparam logic [1:0] S_VERIFY  = LS_VERIFY;
    localparam logic [1:0] S_LOCKED  = LS_LOCKED;

    logic [1:0] r_state;
    logic [7:0] r_min_len;
    logic [6:0] r_win_cnt;
    logic [6:0] r_ui_acc;
    logic       r_armed;
    logic [3:0] r_good_cnt;
    logic [2:0] r_err_cnt;
    logic [9:0] r_idle_cnt;
    logic [7:0] r_cfg_ui, r_cfg_t1, r_cfg_t2, r_cfg_t3;
    logic       r_cfg_valid, r_locked, r_sub_stb, r_err_stb;

    logic [2:0] w_cls;
    logic [7:0] w_new_min;
    thresh_t    w_thr;
    logic       w_win_ok, w_violation, w_start, w_good, w_bad, w_clr;
    logic [7:0] w_acc_sum;
    logic [6:0] w_acc_next;

    spdif_edge_classifier u_cls (
        .i_len (bus.edge_len),
        .i_ui  (r_cfg_ui),
        .i_t1  (r_cfg_t1),
        .i_t2  (r_cfg_t2),
        .i_t3  (r_cfg_t3),
        .o_cls (w_cls)
    );

    assign w_new_min   = (bus.edge_len < r_min_len) ? bus.edge_len : r_min_len;
    assign w_thr       = calc_thresholds(w_new_min);
    assign w_win_ok    = (w_new_min >= 8'(MIN_UI)) && (w_new_min <= 8'(MAX_UI));
    assign w_violation = (w_cls == CLS_RUNT) || (w_cls == CLS_LONG);
    // Inner 3-UI pulses of B/M preambles arrive with ui_acc < 8 and are not starts.
    assign w_start     = (w_cls == CLS_3) && (r_ui_acc >= PREAMBLE_GUARD);
    assign w_good      = w_start && r_armed && (r_ui_acc == SUBFRAME_UI);
    assign w_bad       = w_start && r_armed && (r_ui_acc != SUBFRAME_UI);
    assign w_acc_sum   = {1'b0, r_ui_acc} + {5'd0, w_cls};
    assign w_acc_next  = w_acc_sum[7] ? 7'd127 : w_acc_sum[6:0];

    // Timeout shares the reset path: an edge in the terminal cycle reloads instead.
    assign w_clr = reset || !bus.ena ||
                   (!bus.rx_edge && (r_state != S_IDLE) && (r_idle_cnt == 10'd1));

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state     <= S_IDLE;
            r_min_len   <= 8'hFF;
            r_win_cnt   <= 7'(WIN_EDGES - 1);
            r_ui_acc    <= '0;
            r_armed     <= 1'b0;
            r_good_cnt  <= '0;
            r_err_cnt   <= '0;
            r_idle_cnt  <= 10'(TIMEOUT);
            r_cfg_ui    <= '0;
            r_cfg_t1    <= '0;
            r_cfg_t2    <= '0;
            r_cfg_t3    <= '0;
            r_cfg_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_sub_stb   <= 1'b0;
            r_err_stb   <= 1'b0;
        end else begin
            r_sub_stb <= 1'b0;
            r_err_stb <= 1'b0;
            if (!bus.rx_edge) begin
                if (r_state != S_IDLE)
                    r_idle_cnt <= r_idle_cnt - 10'd1;
            end else begin
                r_idle_cnt <= 10'(TIMEOUT);
                case (r_state)
                    S_IDLE: begin
                        r_state   <= S_MEASURE;
                        r_min_len <= 8'hFF;
                        r_win_cnt <= 7'(WIN_EDGES - 1);
                    end
                    S_MEASURE: begin
                        if (r_win_cnt == 7'd0) begin
                            r_min_len <= 8'hFF;
                            r_win_cnt <= 7'(WIN_EDGES - 1);
                            if (w_win_ok) begin
                                r_cfg_ui    <= w_new_min;
                                r_cfg_t1    <= w_thr.t1;
                                r_cfg_t2    <= w_thr.t2;
                                r_cfg_t3    <= w_thr.t3;
                                r_cfg_valid <= 1'b1;
                                r_state     <= S_VERIFY;
                                r_ui_acc    <= '0;
                                r_armed     <= 1'b0;
                                r_good_cnt  <= '0;
                            end else begin
                                r_cfg_valid <= 1'b0;
                            end
                        end else begin
                            r_min_len <= w_new_min;
                            r_win_cnt <= r_win_cnt - 7'd1;
                        end
                    end
                    default: begin  // VERIFY, LOCKED
                        if (w_start) begin
                            r_ui_acc <= 7'd3;
                            r_armed  <= 1'b1;
                        end else if (!w_violation) begin
                            r_ui_acc <= w_acc_next;
                        end
                        r_err_stb <= w_violation || w_bad;
                        r_sub_stb <= w_good;

                        if (w_violation || w_bad) begin
                            if ((r_state == S_VERIFY) || (r_err_cnt == 3'(ERR_LIMIT - 1))) begin
                                r_state     <= S_MEASURE;
                                r_cfg_valid <= 1'b0;
                                r_locked    <= 1'b0;
                                r_good_cnt  <= '0;
                                r_err_cnt   <= '0;
                                r_min_len   <= 8'hFF;
                                r_win_cnt   <= 7'(WIN_EDGES - 1);
                            end else begin
                                r_err_cnt <= r_err_cnt + 3'd1;
                            end
                        end else if (w_good) begin
                            r_err_cnt <= '0;
                            if (r_state == S_VERIFY) begin
                                if (r_good_cnt == 4'(LOCK_COUNT - 1)) begin
                                    r_state  <= S_LOCKED;
                                    r_locked <= 1'b1;
                                end else begin
                                    r_good_cnt <= r_good_cnt + 4'd1;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.cfg_ui          = r_cfg_ui;
    assign bus.cfg_t1          = r_cfg_t1;
    assign bus.cfg_t2          = r_cfg_t2;
    assign bus.cfg_t3          = r_cfg_t3;
    assign bus.cfg_valid       = r_cfg_valid;
    assign bus.audio_locked    = r_locked;
    assign bus.lock_state      = r_state;
    assign bus.subframe_strobe = r_sub_stb;
    assign bus.err_strobe      = r_err_stb;
endmodule
